execute_cond_stage: RTL
=======================

// Module: execute_cond_stage
// PURPOSE
//   Decode-to-execute boundary of the pipelined ARM core. Captures the decoder's control bundle (plus the instruction
//   Cond field) into E-stage registers, honouring stall/flush. Holds the architectural NZCV flags register and
//   evaluates the condition against it. Emits condition-gated E-stage controls to the datapath, memory stage and
//   hazard unit.
// PARAMETERS
//   none
// PORTS
//   clk          in   1  core clock; all state updates on rising edge
//   reset        in   1  asynchronous, active-low reset (0 = reset)
//   StallE       in   1  hold E-stage control registers and flags
//   FlushE       in   1  replace E-stage contents with a bubble
//   CondD        in   4  Instr[31:28] of the instruction in decode
//   PCSrcD       in   1  decoder: write to PC
//   RegWriteD    in   1  decoder: register write
//   MemtoRegD    in   1  decoder: result from memory
//   MemWriteD    in   1  decoder: memory write
//   ALUControlD  in   5  decoder: ALU operation
//   BranchD      in   1  decoder: branch
//   ALUSrcD      in   1  decoder: immediate operand
//   FlagWriteD   in   2  decoder: [1]=update N,Z  [0]=update C,V
//   NoWriteD     in   1  decoder: compare-type op, suppress Rd write
//   ALUFlags     in   4  {N,Z,C,V} from the E-stage ALU, same cycle
//   PCSrcE       out  1  gated PC write
//   RegWriteE    out  1  gated register write
//   MemtoRegE    out  1  registered MemtoReg (ungated)
//   MemWriteE    out  1  gated memory write
//   ALUControlE  out  5  registered ALU operation
//   ALUSrcE      out  1  registered ALU source select
//   BranchTakenE out  1  gated branch
//   CondExE      out  1  condition passed for a valid E instruction
//   FlagsE       out  4  current flags register {N,Z,C,V} (carry-in for ADC/SBC)
// BEHAVIOUR
//   - State: ValidE, CondE[3:0], registered copies of every D control input, Flags[3:0].
//   - Reset (async, reset==0): every register 0, so all outputs 0; FlagsE=4'b0000.
//   - Capture, each rising edge, in priority order:
//     - FlushE=1: bubble (ValidE=0, all control regs 0, CondE=0). FlushE takes priority over StallE.
//     - else StallE=1: hold all E registers.
//     - else load the D inputs; ValidE=1.
//   - Latency: D inputs appear on E outputs one cycle after capture.
//   - Condition eval (combinational on CondE, Flags):
//     - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
//     - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
//     - AL 1; 4'b1111 -> 0 (never).
//   - CondExE = ValidE & cond_pass.
//   - Gated outputs: PCSrcE=PCSrcRegE&CondExE; MemWriteE=MemWriteRegE&CondExE; BranchTakenE=BranchRegE&CondExE;
//     RegWriteE=RegWriteRegE&CondExE&~NoWriteRegE.
//   - Flags update at edge when CondExE & ~StallE:
//     - FlagWriteE[1] -> Flags[3:2]<=ALUFlags[3:2]
//     - FlagWriteE[0] -> Flags[1:0]<=ALUFlags[1:0]
//     - Halves update independently.
//   - Flags are never written while StallE=1, so a held instruction is evaluated against pre-instruction flags on
//     every stalled cycle. A failed or bubble instruction never writes flags.
//   - The condition uses the flags register value before this instruction. The next instruction in E sees the
//     updated flags; no internal flag forwarding.
//   - FlushE and FlagWrite in the same cycle: the flag write of the current E instruction still occurs (gated by its
//     own CondExE, StallE=0). The flush only affects the next E contents.
//   - Reset mid-operation discards the E instruction and clears the flags immediately.
// TESTING
//   1. Reset: reset=0 with D controls all 1 -> all outputs 0, FlagsE=0000. Release, then one edge -> outputs follow D.
//   2. CMP then BEQ: CMP loaded with FlagWriteD=11, NoWriteD=1, ALUFlags=0100 -> RegWriteE=0, FlagsE=0100 next cycle.
//      Next instruction BranchD=1, PCSrcD=1, CondD=0000 -> BranchTakenE=1, PCSrcE=1.
//   3. Failed cond: Flags=0000, CondD=0000 with RegWriteD=MemWriteD=1, FlagWriteD=11, ALUFlags=1111 -> RegWriteE=0,
//      MemWriteE=0, CondExE=0, FlagsE stays 0000.
//   4. Partial update: Flags=0011, FlagWriteD=10, ALUFlags=1100, CondD=1110 -> FlagsE=1111.
//      Then FlagWriteD=01 with ALUFlags=0000 -> FlagsE=1100.
//   5. Stall/flush: load ADDS (CondD=1110, FlagWriteD=11, ALUFlags=1000), StallE=1 for 2 cycles -> outputs held,
//      FlagsE unchanged until the first edge with StallE=0. Assert FlushE with StallE=1 -> next cycle CondExE=0,
//      all gated outputs 0.
//   6. Sweep all 16 CondD values x 16 flag values with RegWriteD=1 -> RegWriteE matches the condition table,
//      4'b1111 always 0.

Source files
------------

// File: rtl/execute_cond_stage_if.sv
// Decode-to-execute control bundle: D-stage controls, hazard controls and ALU flags in,
// condition-gated E-stage controls out.
interface execute_cond_stage_if;
    logic       StallE;
    logic       FlushE;
    logic [3:0] CondD;
    logic       PCSrcD;
    logic       RegWriteD;
    logic       MemtoRegD;
    logic       MemWriteD;
    logic [4:0] ALUControlD;
    logic       BranchD;
    logic       ALUSrcD;
    logic [1:0] FlagWriteD;
    logic       NoWriteD;
    logic [3:0] ALUFlags;
    logic       PCSrcE;
    logic       RegWriteE;
    logic       MemtoRegE;
    logic       MemWriteE;
    logic [4:0] ALUControlE;
    logic       ALUSrcE;
    logic       BranchTakenE;
    logic       CondExE;
    logic [3:0] FlagsE;

    modport master (
        output StallE, FlushE, CondD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD,
               ALUControlD, BranchD, ALUSrcD, FlagWriteD, NoWriteD, ALUFlags,
        input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE,
               BranchTakenE, CondExE, FlagsE
    );

    modport slave (
        input  StallE, FlushE, CondD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD,
               ALUControlD, BranchD, ALUSrcD, FlagWriteD, NoWriteD, ALUFlags,
        output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE,
               BranchTakenE, CondExE, FlagsE
    );
endinterface

// File: rtl/execute_cond_stage.sv
// E-stage control registers with stall/flush, the NZCV flags register and ARM condition
// evaluation that gates the side-effecting E-stage controls.
module execute_cond_stage (
    input logic                 clk,
    input logic                 reset,
    execute_cond_stage_if.slave bus
);

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } condCodeT;

    logic       validE;
    condCodeT   condE;
    logic       pcSrcRegE;
    logic       regWriteRegE;
    logic       memtoRegE;
    logic       memWriteRegE;
    logic [4:0] aluControlE;
    logic       branchRegE;
    logic       aluSrcE;
    logic [1:0] flagWriteE;
    logic       noWriteRegE;
    logic [3:0] flags;
    logic       condPass;
    logic       condExE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validE       <= 1'b0;
            condE        <= EQ;
            pcSrcRegE    <= 1'b0;
            regWriteRegE <= 1'b0;
            memtoRegE    <= 1'b0;
            memWriteRegE <= 1'b0;
            aluControlE  <= '0;
            branchRegE   <= 1'b0;
            aluSrcE      <= 1'b0;
            flagWriteE   <= '0;
            noWriteRegE  <= 1'b0;
            flags        <= '0;
        end else begin
            if (bus.FlushE) begin
                validE       <= 1'b0;
                condE        <= EQ;
                pcSrcRegE    <= 1'b0;
                regWriteRegE <= 1'b0;
                memtoRegE    <= 1'b0;
                memWriteRegE <= 1'b0;
                aluControlE  <= '0;
                branchRegE   <= 1'b0;
                aluSrcE      <= 1'b0;
                flagWriteE   <= '0;
                noWriteRegE  <= 1'b0;
            end else if (!bus.StallE) begin
                validE       <= 1'b1;
                condE        <= condCodeT'(bus.CondD);
                pcSrcRegE    <= bus.PCSrcD;
                regWriteRegE <= bus.RegWriteD;
                memtoRegE    <= bus.MemtoRegD;
                memWriteRegE <= bus.MemWriteD;
                aluControlE  <= bus.ALUControlD;
                branchRegE   <= bus.BranchD;
                aluSrcE      <= bus.ALUSrcD;
                flagWriteE   <= bus.FlagWriteD;
                noWriteRegE  <= bus.NoWriteD;
            end
            // The retiring E instruction still commits its flags even when the next slot is flushed.
            if (condExE && !bus.StallE) begin
                if (flagWriteE[1]) flags[3:2] <= bus.ALUFlags[3:2];
                if (flagWriteE[0]) flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        condPass = 1'b0;
        unique case (condE)
            EQ: condPass = flags[2];
            NE: condPass = !flags[2];
            CS: condPass = flags[1];
            CC: condPass = !flags[1];
            MI: condPass = flags[3];
            PL: condPass = !flags[3];
            VS: condPass = flags[0];
            VC: condPass = !flags[0];
            HI: condPass = flags[1] && !flags[2];
            LS: condPass = !flags[1] || flags[2];
            GE: condPass = (flags[3] == flags[0]);
            LT: condPass = (flags[3] != flags[0]);
            GT: condPass = !flags[2] && (flags[3] == flags[0]);
            LE: condPass = flags[2] || (flags[3] != flags[0]);
            AL: condPass = 1'b1;
            NV: condPass = 1'b0;
            default: condPass = 1'b0;
        endcase
    end

    assign condExE          = validE & condPass;
    assign bus.CondExE      = condExE;
    assign bus.PCSrcE       = pcSrcRegE & condExE;
    assign bus.MemWriteE    = memWriteRegE & condExE;
    assign bus.BranchTakenE = branchRegE & condExE;
    assign bus.RegWriteE    = regWriteRegE & condExE & ~noWriteRegE;
    assign bus.MemtoRegE    = memtoRegE;
    assign bus.ALUControlE  = aluControlE;
    assign bus.ALUSrcE      = aluSrcE;
    assign bus.FlagsE       = flags;

endmodule
